// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution stage.
// BRANCH_STATS_EN adds the performance counter ports.
package branch_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CMP_W = 4;
   localparam int unsigned CNT_W = 4;

   // Conditional comparator op codes; anything outside [CMP_SLT:CMP_BNE] is never taken
   localparam logic [CMP_W-1:0] CMP_SLT  = 4'b0100;
   localparam logic [CMP_W-1:0] CMP_SLTU = 4'b0101;
   localparam logic [CMP_W-1:0] CMP_SGE  = 4'b0110;
   localparam logic [CMP_W-1:0] CMP_SGEU = 4'b0111;
   localparam logic [CMP_W-1:0] CMP_BEQ  = 4'b1000;
   localparam logic [CMP_W-1:0] CMP_BNE  = 4'b1001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } br_state_t;

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] redirect_pc;
      logic [XLEN-1:0] link_value;
      logic            mispredict;
      logic            misaligned;
   } br_result_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-side and redirect-side signals of branch_resolve.
// BRANCH_STATS_EN adds branch_count / mispredict_count.
interface branch_resolve_if;
   import branch_pkg::*;

   logic              valid_in;
   logic              ready_in;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   imm;
   logic [XLEN-1:0]   rs1;
   logic [CMP_W-1:0]  comparison;
   logic              cmp_result;
   logic              is_jal;
   logic              is_jalr;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic              valid_out;
   logic              ready_out;
   logic              taken;
   logic [XLEN-1:0]   redirect_pc;
   logic [XLEN-1:0]   link_value;
   logic              mispredict;
   logic              misaligned;
   logic              flush;
`ifdef BRANCH_STATS_EN
   logic [XLEN-1:0]   branch_count;
   logic [XLEN-1:0]   mispredict_count;
`endif

   // Stage side
   modport slave (
      input  valid_in, pc, imm, rs1, comparison, cmp_result, is_jal, is_jalr,
             pred_taken, pred_target, ready_out,
      output ready_in, valid_out, taken, redirect_pc, link_value, mispredict,
             misaligned, flush
`ifdef BRANCH_STATS_EN
      , output branch_count, mispredict_count
`endif
   );

   // Execute / fetch side
   modport master (
      output valid_in, pc, imm, rs1, comparison, cmp_result, is_jal, is_jalr,
             pred_taken, pred_target, ready_out,
      input  ready_in, valid_out, taken, redirect_pc, link_value, mispredict,
             misaligned, flush
`ifdef BRANCH_STATS_EN
      , input branch_count, mispredict_count
`endif
   );

endinterface

// File: rtl/branch_target_calc.sv
// Combinational direction, target, link and misalignment for one branch.
module branch_target_calc
   import branch_pkg::*;
(
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1,
   input  logic [CMP_W-1:0] comparison,
   input  logic             cmp_result,
   input  logic             is_jal,
   input  logic             is_jalr,
   output logic             taken_c,
   output logic [XLEN-1:0]  target_c,
   output logic [XLEN-1:0]  link_c,
   output logic [XLEN-1:0]  redirect_c,
   output logic             misaligned_c
);

   logic is_cond;

   assign is_cond      = (comparison >= CMP_SLT) && (comparison <= CMP_BNE);
   assign taken_c      = is_jal | is_jalr | (is_cond & cmp_result);
   // JALR wins when both jump flags are set
   assign target_c     = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : (pc + imm);
   assign link_c       = pc + XLEN'(4);
   assign redirect_c   = taken_c ? target_c : link_c;
   assign misaligned_c = taken_c & target_c[1];

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: registered result, mispredict redirect and timed flush.
// BRANCH_STATS_EN enables saturating branch / mispredict counters.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   branch_resolve_if.slave  bus
);

   br_state_t        state_q, state_d;
   br_result_t       res_q, res_d, res_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_c;

   logic             taken_c;
   logic             misaligned_c;
   logic [XLEN-1:0]  target_c;
   logic [XLEN-1:0]  link_c;
   logic [XLEN-1:0]  redirect_c;

   branch_target_calc u_calc (
      .pc           (bus.pc),
      .imm          (bus.imm),
      .rs1          (bus.rs1),
      .comparison   (bus.comparison),
      .cmp_result   (bus.cmp_result),
      .is_jal       (bus.is_jal),
      .is_jalr      (bus.is_jalr),
      .taken_c      (taken_c),
      .target_c     (target_c),
      .link_c       (link_c),
      .redirect_c   (redirect_c),
      .misaligned_c (misaligned_c)
   );

   // Misaligned targets go to the exception path, never to a redirect
   always_comb begin
      res_c.taken       = taken_c;
      res_c.redirect_pc = redirect_c;
      res_c.link_value  = link_c;
      res_c.misaligned  = misaligned_c;
      res_c.mispredict  = !misaligned_c &&
                          ((taken_c != bus.pred_taken) ||
                           (taken_c && (target_c != bus.pred_target)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      ready_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.valid_in) begin
               state_d = HOLD;
               res_d   = res_c;
            end
         end
         HOLD: begin
            if (bus.ready_out) begin
               if (res_q.mispredict) begin
                  state_d = FLUSH;
                  cnt_d   = CNT_W'(FLUSH_CYCLES);
               end else begin
                  ready_c = 1'b1;
                  if (bus.valid_in) begin
                     state_d = HOLD;
                     res_d   = res_c;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready_in    = ready_c;
   assign bus.valid_out   = (state_q == HOLD);
   assign bus.flush       = (state_q == FLUSH);
   assign bus.taken       = res_q.taken;
   assign bus.redirect_pc = res_q.redirect_pc;
   assign bus.link_value  = res_q.link_value;
   assign bus.mispredict  = res_q.mispredict;
   assign bus.misaligned  = res_q.misaligned;

`ifdef BRANCH_STATS_EN
   logic            hs;
   logic [XLEN-1:0] branch_cnt_q;
   logic [XLEN-1:0] mp_cnt_q;

   assign hs = (state_q == HOLD) && bus.ready_out;

   // Saturating counters, one step per output handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q <= '0;
         mp_cnt_q     <= '0;
      end else if (hs) begin
         if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + XLEN'(1);
         if (res_q.mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + XLEN'(1);
      end
   end

   assign bus.branch_count     = branch_cnt_q;
   assign bus.mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed table, corner sequences, random vs model.
module tb_branch_resolve;

   localparam int unsigned FLUSH_CYCLES = 2;

   typedef struct {
      logic [31:0] pc, imm, rs1;
      logic [3:0]  comparison;
      logic        cmp_result, is_jal, is_jalr, pred_taken;
      logic [31:0] pred_target;
   } in_t;

   typedef struct {
      logic        taken;
      logic [31:0] redirect_pc, link_value;
      logic        mispredict, misaligned;
   } res_t;

   typedef struct {
      in_t  i;
      res_t e;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_bc = 0;
   int   exp_mc = 0;
   vec_t tbl[11];

   branch_resolve_if bus();

   branch_resolve #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_res(input string tag, input res_t e);
      chk({tag, ".taken"},       32'(bus.taken),      32'(e.taken));
      chk({tag, ".redirect_pc"}, bus.redirect_pc,     e.redirect_pc);
      chk({tag, ".link_value"},  bus.link_value,      e.link_value);
      chk({tag, ".mispredict"},  32'(bus.mispredict), 32'(e.mispredict));
      chk({tag, ".misaligned"},  32'(bus.misaligned), 32'(e.misaligned));
   endtask

   task automatic drive(input in_t i, input logic v);
      bus.valid_in    = v;
      bus.pc          = i.pc;
      bus.imm         = i.imm;
      bus.rs1         = i.rs1;
      bus.comparison  = i.comparison;
      bus.cmp_result  = i.cmp_result;
      bus.is_jal      = i.is_jal;
      bus.is_jalr     = i.is_jalr;
      bus.pred_taken  = i.pred_taken;
      bus.pred_target = i.pred_target;
   endtask

   // Reference: direct reading of the resolution rules
   function automatic res_t model(input in_t i);
      res_t        r;
      logic [31:0] tgt;
      logic        cond;
      if (i.is_jalr) tgt = (i.rs1 + i.imm) & 32'hFFFF_FFFE;
      else           tgt = i.pc + i.imm;
      cond          = (i.comparison >= 4'd4) && (i.comparison <= 4'd9);
      r.taken       = i.is_jal || i.is_jalr || (cond && i.cmp_result);
      r.link_value  = i.pc + 32'd4;
      r.redirect_pc = r.taken ? tgt : r.link_value;
      r.misaligned  = r.taken && tgt[1];
      r.mispredict  = !r.misaligned &&
                      ((r.taken != i.pred_taken) || (r.taken && (tgt != i.pred_target)));
      return r;
   endfunction

   function automatic vec_t mk(input logic [31:0] pc, imm, rs1, input logic [3:0] cmp,
                               input logic cr, jal, jalr, pt, input logic [31:0] ptgt,
                               input logic tk, input logic [31:0] red, lnk,
                               input logic mp, mis);
      vec_t v;
      v.i.pc = pc; v.i.imm = imm; v.i.rs1 = rs1; v.i.comparison = cmp;
      v.i.cmp_result = cr; v.i.is_jal = jal; v.i.is_jalr = jalr;
      v.i.pred_taken = pt; v.i.pred_target = ptgt;
      v.e.taken = tk; v.e.redirect_pc = red; v.e.link_value = lnk;
      v.e.mispredict = mp; v.e.misaligned = mis;
      return v;
   endfunction

   function automatic in_t rnd_in();
      in_t  i;
      res_t r;
      i.pc          = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 | ($urandom() & 32'hC) : $urandom() & 32'hFFFF_FFFC;
      i.imm         = ($urandom_range(3) == 0) ? $urandom() : $urandom() & 32'hFFFF_FFFC;
      i.rs1         = $urandom();
      i.comparison  = 4'($urandom());
      i.cmp_result  = 1'($urandom());
      i.is_jal      = ($urandom_range(7) == 0);
      i.is_jalr     = ($urandom_range(7) == 0);
      i.pred_taken  = 1'($urandom());
      i.pred_target = $urandom();
      r = model(i);
      if ($urandom_range(3) != 0) i.pred_taken = r.taken;
      if ($urandom_range(1) == 0) i.pred_target = r.redirect_pc;
      return r.taken ? i : i;
   endfunction

   // Single branch from IDLE with ready_out high, including any flush that follows
   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      drive(v.i, 1'b1);
      bus.ready_out = 1'b1;
      #1 chk({tag, ".ready_in_idle"}, 32'(bus.ready_in), 32'd1);
      @(negedge clk);
      bus.valid_in = 1'b0;
      chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'd1);
      check_res(tag, v.e);
      exp_bc++;
      if (v.e.mispredict) exp_mc++;
      @(negedge clk);
      if (v.e.mispredict) begin
         for (int k = 0; k < int'(FLUSH_CYCLES); k++) begin
            chk({tag, ".flush_on"},     32'(bus.flush),     32'd1);
            chk({tag, ".ready_in_fl"},  32'(bus.ready_in),  32'd0);
            chk({tag, ".valid_out_fl"}, 32'(bus.valid_out), 32'd0);
            @(negedge clk);
         end
      end
      chk({tag, ".flush_off"}, 32'(bus.flush),     32'd0);
      chk({tag, ".idle"},      32'(bus.valid_out), 32'd0);
   endtask

   initial begin
      in_t  cur;
      in_t  b;
      logic vin;
      logic ro;
      bit   stalled;
      bit   exp_rdy;
      bit   pend;
      res_t pend_res;
      int   flush_left;

      //          pc            imm           rs1           cmp    cr jal jalr pt ptgt           tk red           link          mp mis
      tbl[0]  = mk(32'h100,      32'h20,       32'h0,        4'b1000, 1, 0, 0, 0, 32'h0,        1, 32'h120,      32'h104,      1, 0);
      tbl[1]  = mk(32'h200,      32'h40,       32'h0,        4'b1001, 0, 0, 0, 0, 32'h0,        0, 32'h204,      32'h204,      0, 0);
      tbl[2]  = mk(32'h300,      32'h0,        32'h1003,     4'b0000, 0, 0, 1, 1, 32'h1002,     1, 32'h1002,     32'h304,      0, 1);
      tbl[3]  = mk(32'hFFFF_FFFC, 32'h8,       32'h0,        4'b0100, 1, 0, 0, 1, 32'h4,        1, 32'h4,        32'h0,        0, 0);
      tbl[4]  = mk(32'hFFFF_FFFC, 32'h6,       32'h0,        4'b0100, 1, 0, 0, 0, 32'h0,        1, 32'h2,        32'h0,        0, 1);
      tbl[5]  = mk(32'h400,      32'h10,       32'h0,        4'b0000, 1, 0, 0, 1, 32'h410,      0, 32'h404,      32'h404,      1, 0);
      tbl[6]  = mk(32'h500,      32'h8,        32'h2000,     4'b0000, 0, 1, 1, 1, 32'h2008,     1, 32'h2008,     32'h504,      0, 0);
      tbl[7]  = mk(32'h600,      32'h100,      32'h0,        4'b0000, 0, 1, 0, 1, 32'h704,      1, 32'h700,      32'h604,      1, 0);
      tbl[8]  = mk(32'h800,      32'hFFFF_FFF0, 32'h0,       4'b1000, 1, 0, 0, 1, 32'h7F0,      1, 32'h7F0,      32'h804,      0, 0);
      tbl[9]  = mk(32'h900,      32'hC,        32'h0,        4'b0111, 1, 0, 0, 0, 32'h0,        1, 32'h90C,      32'h904,      1, 0);
      tbl[10] = mk(32'hA00,      32'h4,        32'h0,        4'b1010, 1, 0, 0, 0, 32'h0,        0, 32'hA04,      32'hA04,      0, 0);

      rst_n = 1'b0;
      b = tbl[1].i;
      drive(b, 1'b0);
      bus.ready_out = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      chk("rst.valid_out",   32'(bus.valid_out),  32'd0);
      chk("rst.flush",       32'(bus.flush),      32'd0);
      chk("rst.taken",       32'(bus.taken),      32'd0);
      chk("rst.mispredict",  32'(bus.mispredict), 32'd0);
      chk("rst.misaligned",  32'(bus.misaligned), 32'd0);
      chk("rst.redirect_pc", bus.redirect_pc,     32'd0);
      chk("rst.link_value",  bus.link_value,      32'd0);
      chk("rst.ready_in",    32'(bus.ready_in),   32'd1);
`ifdef BRANCH_STATS_EN
      chk("rst.branch_count",     bus.branch_count,     32'd0);
      chk("rst.mispredict_count", bus.mispredict_count, 32'd0);
`endif

      for (int n = 0; n < 11; n++) run_vec(tbl[n], n);

      // Back-to-back correctly predicted branches, one per cycle
      b = tbl[1].i;
      for (int k = 0; k < 3; k++) begin
         b.pc = 32'h200 + 32'(8 * k);
         drive(b, 1'b1);
         bus.ready_out = 1'b1;
         #1 chk("b2b.ready_in", 32'(bus.ready_in), 32'd1);
         @(negedge clk);
         chk("b2b.valid_out", 32'(bus.valid_out), 32'd1);
         chk("b2b.redirect_pc", bus.redirect_pc, 32'h204 + 32'(8 * k));
         exp_bc++;
      end
      bus.valid_in = 1'b0;
      @(negedge clk);
      chk("b2b.idle", 32'(bus.valid_out), 32'd0);

      // Back-pressure: result frozen, next branch waits
      drive(tbl[8].i, 1'b1);
      bus.ready_out = 1'b0;
      @(negedge clk);
      drive(tbl[1].i, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp.valid_out", 32'(bus.valid_out), 32'd1);
         chk("bp.ready_in",  32'(bus.ready_in),  32'd0);
         check_res("bp.frozen", tbl[8].e);
         @(negedge clk);
      end
      bus.ready_out = 1'b1;
      #1 chk("bp.ready_in_release", 32'(bus.ready_in), 32'd1);
      exp_bc++;
      @(negedge clk);
      bus.valid_in = 1'b0;
      chk("bp.second_valid", 32'(bus.valid_out), 32'd1);
      check_res("bp.second", tbl[1].e);
      exp_bc++;
      @(negedge clk);
      chk("bp.idle", 32'(bus.valid_out), 32'd0);

      // Asynchronous reset in the middle of a flush
      drive(tbl[0].i, 1'b1);
      bus.ready_out = 1'b1;
      @(negedge clk);
      bus.valid_in = 1'b0;
      chk("rf.mispredict", 32'(bus.mispredict), 32'd1);
      @(negedge clk);
      chk("rf.flush_before", 32'(bus.flush), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rf.flush",       32'(bus.flush),     32'd0);
      chk("rf.valid_out",   32'(bus.valid_out), 32'd0);
      chk("rf.taken",       32'(bus.taken),     32'd0);
      chk("rf.redirect_pc", bus.redirect_pc,    32'd0);
      chk("rf.ready_in",    32'(bus.ready_in),  32'd1);
      exp_bc = 0;
      exp_mc = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the reference model
      pend = 0; flush_left = 0; stalled = 0; vin = 0;
      cur = tbl[1].i;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd.valid_out", 32'(bus.valid_out), 32'(pend));
         chk("rnd.flush",     32'(bus.flush),     32'(flush_left > 0));
         if (pend) check_res("rnd", pend_res);
         if (!stalled) begin
            vin = ($urandom_range(9) < 6);
            cur = rnd_in();
         end
         ro = ($urandom_range(3) != 0);
         if (c >= 2900) begin
            vin = stalled;
            ro  = 1'b1;
         end
         drive(cur, vin);
         bus.ready_out = ro;
         #1;
         exp_rdy = (!pend && flush_left == 0) || (pend && ro && !pend_res.mispredict);
         chk("rnd.ready_in", 32'(bus.ready_in), 32'(exp_rdy));
         if (flush_left > 0) flush_left--;
         if (pend && ro) begin
            exp_bc++;
            if (pend_res.mispredict) begin
               exp_mc++;
               flush_left = FLUSH_CYCLES;
            end
            pend = 0;
         end
         if (vin && exp_rdy) begin
            pend     = 1;
            pend_res = model(cur);
         end
         stalled = vin && !exp_rdy;
         @(negedge clk);
      end

`ifdef BRANCH_STATS_EN
      chk("branch_count",     bus.branch_count,     32'(exp_bc));
      chk("mispredict_count", bus.mispredict_count, 32'(exp_mc));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
